sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 86 ++++++++
 tb/tb_sync_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and a count-based empty/full.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_EN is defined.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_write,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_read,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic             o_overflow,
    output logic             o_underflow
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;

    logic rd_accept;
    logic wr_accept;

    // Handshake: a pop is taken whenever i_read=1 and the FIFO is not empty;
    // a push is taken whenever i_write=1 and there is room, where a same-edge
    // pop frees the slot of a full FIFO. Refused requests leave no trace.
    assign o_empty   = (count == '0);
    assign o_full    = (count == CW'(DEPTH));
    assign rd_accept = i_read && !o_empty;
    assign wr_accept = i_write && (!o_full || rd_accept);

    // Storage is deliberately left out of reset; pointers make stale data unreachable.
    always_ff @(posedge i_clock) begin
        if (wr_accept && i_reset_n) begin
            mem[wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            o_rdata <= '0;
        end else begin
            if (wr_accept) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_accept) begin
                rptr    <= rptr + AW'(1);
                o_rdata <= mem[rptr];
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_write && !wr_accept) begin
                o_overflow <= 1'b1;
            end
            if (i_read && o_empty) begin
                o_underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DEPTH=4, WIDTH=8) with immediate-assertion checks.
// Exercises the SYNC_FIFO_ERR_EN flags too when that macro is defined.
module tb_sync_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    logic             i_clock;
    logic             i_reset_n;
    logic             i_write;
    logic [WIDTH-1:0] i_wdata;
    logic             i_read;
    logic [WIDTH-1:0] o_rdata;
    logic             o_empty;
    logic             o_full;
`ifdef SYNC_FIFO_ERR_EN
    logic             o_overflow;
    logic             o_underflow;
`endif

    int n_compared;
    int n_mismatched;
    logic [WIDTH-1:0] exp_q[$];

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_write    (i_write),
        .i_wdata    (i_wdata),
        .i_read     (i_read),
        .o_rdata    (o_rdata),
        .o_empty    (o_empty),
        .o_full     (o_full)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .o_overflow (o_overflow),
        .o_underflow(o_underflow)
`endif
    );

    // clock / reset block
    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks: inputs change 1 time unit after a rising edge, checks follow there
    task automatic push(input logic [WIDTH-1:0] d);
        i_write = 1'b1;
        i_wdata = d;
        @(posedge i_clock);
        #1;
        i_write = 1'b0;
    endtask

    task automatic pop();
        i_read = 1'b1;
        @(posedge i_clock);
        #1;
        i_read = 1'b0;
    endtask

    task automatic push_pop(input logic [WIDTH-1:0] d);
        i_write = 1'b1;
        i_read  = 1'b1;
        i_wdata = d;
        @(posedge i_clock);
        #1;
        i_write = 1'b0;
        i_read  = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] e;
        n_compared   = 0;
        n_mismatched = 0;
        i_reset_n = 1'b0;
        i_write   = 1'b0;
        i_read    = 1'b0;
        i_wdata   = '0;

        // reset state before any clock edge
        #1;
        check("reset_empty", 32'(o_empty), 32'd1);
        check("reset_full", 32'(o_full), 32'd0);
        check("reset_rdata", 32'(o_rdata), 32'h00);
        repeat (2) @(posedge i_clock);
        #1;
        i_reset_n = 1'b1;

        // read while empty is ignored
        pop();
        check("empty_rd_rdata", 32'(o_rdata), 32'h00);
        check("empty_rd_empty", 32'(o_empty), 32'd1);
`ifdef SYNC_FIFO_ERR_EN
        check("underflow_set", 32'(o_underflow), 32'd1);
        check("overflow_clear", 32'(o_overflow), 32'd0);
`endif

        // fill to full, then a dropped write
        push(8'h11);
        check("one_entry_empty", 32'(o_empty), 32'd0);
        push(8'h22);
        push(8'h33);
        check("three_full", 32'(o_full), 32'd0);
        push(8'h44);
        check("four_full", 32'(o_full), 32'd1);
        push(8'h55);
        check("drop_full", 32'(o_full), 32'd1);
`ifdef SYNC_FIFO_ERR_EN
        check("overflow_set", 32'(o_overflow), 32'd1);
`endif

        // drain in order; 0x55 must not appear
        pop();
        check("rd0_data", 32'(o_rdata), 32'h11);
        check("rd0_full", 32'(o_full), 32'd0);
        pop();
        check("rd1_data", 32'(o_rdata), 32'h22);
        pop();
        check("rd2_data", 32'(o_rdata), 32'h33);
        pop();
        check("rd3_data", 32'(o_rdata), 32'h44);
        check("drained_empty", 32'(o_empty), 32'd1);
        pop();
        check("hold_rdata", 32'(o_rdata), 32'h44);

        // simultaneous read+write with one entry stored
        push(8'h5A);
        push_pop(8'h6B);
        check("mid_rw_data", 32'(o_rdata), 32'h5A);
        check("mid_rw_empty", 32'(o_empty), 32'd0);
        pop();
        check("mid_rw_next", 32'(o_rdata), 32'h6B);
        check("mid_rw_drained", 32'(o_empty), 32'd1);

        // simultaneous read+write on empty accepts only the write
        push_pop(8'h7C);
        check("empty_rw_rdata", 32'(o_rdata), 32'h6B);
        check("empty_rw_empty", 32'(o_empty), 32'd0);
        pop();
        check("empty_rw_data", 32'(o_rdata), 32'h7C);

        // full FIFO, read+write 0xAA on the same edge
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        check("refill_full", 32'(o_full), 32'd1);
        push_pop(8'hAA);
        check("full_rw_data", 32'(o_rdata), 32'h01);
        check("full_rw_full", 32'(o_full), 32'd1);
        pop();
        check("full_rw_rd1", 32'(o_rdata), 32'h02);
        pop();
        check("full_rw_rd2", 32'(o_rdata), 32'h03);
        pop();
        check("full_rw_rd3", 32'(o_rdata), 32'h04);
        pop();
        check("full_rw_last", 32'(o_rdata), 32'hAA);
        check("full_rw_empty", 32'(o_empty), 32'd1);

        // ten write/read pairs walk the pointers around several times
        for (int i = 0; i < 10; i++) begin
            v = WIDTH'(i * 8'h13 + 8'h05);
            push(v);
            exp_q.push_back(v);
            pop();
            e = exp_q.pop_front();
            check($sformatf("wrap_%0d", i), 32'(o_rdata), 32'(e));
        end
        check("wrap_empty", 32'(o_empty), 32'd1);

        // asynchronous reset with two entries stored
        push(8'hC1);
        push(8'hC2);
        check("pre_reset_empty", 32'(o_empty), 32'd0);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("async_rst_empty", 32'(o_empty), 32'd1);
        check("async_rst_full", 32'(o_full), 32'd0);
        check("async_rst_rdata", 32'(o_rdata), 32'h00);
        @(posedge i_clock);
        #1;
        i_reset_n = 1'b1;
`ifdef SYNC_FIFO_ERR_EN
        check("rst_overflow", 32'(o_overflow), 32'd0);
        check("rst_underflow", 32'(o_underflow), 32'd0);
`endif
        pop();
        check("post_rst_rdata", 32'(o_rdata), 32'h00);
        check("post_rst_empty", 32'(o_empty), 32'd1);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
